// File: rtl/quad_pkg.sv
// Shared types and constants for the quadrature decoder.
package quad_pkg;

  // Decoder control states.
  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Cycles spent in ST_INIT after reset releases.
  localparam int unsigned INIT_CYCLES = 3;
  localparam int unsigned INIT_CNT_W  = $clog2(INIT_CYCLES);

  // Direction encoding for up_down.
  localparam logic UP   = 1'b1;
  localparam logic DOWN = 1'b0;

  // Next phase {A,B} in the up direction: 00 -> 01 -> 11 -> 10 -> 00.
  function automatic logic [1:0] up_next(input logic [1:0] ph);
    logic [1:0] nxt;
    nxt = 2'b00;
    unique case (ph)
      2'b00: nxt = 2'b01;
      2'b01: nxt = 2'b11;
      2'b11: nxt = 2'b10;
      2'b10: nxt = 2'b00;
      default: nxt = 2'b00;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/debounce_filter.sv
// Two-flop synchroniser followed by a persistence filter for one encoder channel.
module debounce_filter #(
  parameter int unsigned DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic bypass,
  input  logic din,
  output logic dout
);

  localparam int unsigned         CNT_W    = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;

  // Bring the asynchronous channel into the clk domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
    end
  end

  // Accept a new level only after it has persisted for DEB_CYCLES cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout <= 1'b0;
      cnt  <= '0;
    end else if (bypass) begin
      dout <= s2;
      cnt  <= '0;
    end else if (s2 != dout) begin
      if (cnt == CNT_LAST) begin
        dout <= s2;
        cnt  <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end else begin
      cnt <= '0;
    end
  end

endmodule

// File: rtl/quad_decoder.sv
// Quadrature decoder: debounced A/B channels to step strobe, direction and error pulse.
module quad_decoder
  import quad_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic a_in,
  input  logic b_in,
  output logic step,
  output logic up_down,
  output logic err
);

  state_t                state;
  logic [INIT_CNT_W-1:0] init_cnt;
  logic                  settled;
  logic                  bypass;
  logic                  deb_a;
  logic                  deb_b;
  logic [1:0]            cur;
  logic [1:0]            prev;

  // Filters load their synchronised input directly while initialising.
  always_comb begin
    bypass = (state == ST_INIT);
    cur    = {deb_a, deb_b};
  end

  debounce_filter #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_deb_a (
    .clk   (clk),
    .rst   (rst),
    .bypass(bypass),
    .din   (a_in),
    .dout  (deb_a)
  );

  debounce_filter #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_deb_b (
    .clk   (clk),
    .rst   (rst),
    .bypass(bypass),
    .din   (b_in),
    .dout  (deb_b)
  );

  // Control FSM, phase history and registered decode outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_INIT;
      init_cnt <= '0;
      settled  <= 1'b0;
      prev     <= '0;
      step     <= 1'b0;
      err      <= 1'b0;
      up_down  <= UP;
    end else begin
      step <= 1'b0;
      err  <= 1'b0;
      prev <= cur;
      unique case (state)
        ST_INIT: begin
          settled <= 1'b0;
          if (init_cnt == INIT_CNT_W'(INIT_CYCLES - 1)) begin
            state    <= ST_RUN;
            init_cnt <= '0;
          end else begin
            init_cnt <= init_cnt + INIT_CNT_W'(1);
          end
        end
        ST_RUN: begin
          // The bypassed value loaded on the last INIT edge is still one
          // cycle ahead of prev, so the first RUN cycle only realigns prev.
          settled <= 1'b1;
          if (settled && (cur != prev)) begin
            if (cur == up_next(prev)) begin
              step    <= 1'b1;
              up_down <= UP;
            end else if (prev == up_next(cur)) begin
              step    <= 1'b1;
              up_down <= DOWN;
            end else begin
              err <= 1'b1;
            end
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_quad_decoder.sv
// Scoreboard bench for quad_decoder with DEB_CYCLES = 4.
module tb_quad_decoder;
  import quad_pkg::*;

  localparam int unsigned DEB = 4;
  localparam int          LAT = DEB + 3;

  typedef struct {
    int   cyc;
    logic step;
    logic err;
    logic ud;
  } exp_t;

  logic clk;
  logic rst;
  logic a_in;
  logic b_in;
  logic step;
  logic up_down;
  logic err;

  int   cyc;
  int   vectors;
  int   miscompares;
  int   pulse_cnt;
  logic last_ud;
  exp_t exp_q[$];

  logic [1:0] model_ph;
  logic       model_ud;

  quad_decoder #(
    .DEB_CYCLES(DEB)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .a_in   (a_in),
    .b_in   (b_in),
    .step   (step),
    .up_down(up_down),
    .err    (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Position of a phase around the up cycle 00,01,11,10.
  function automatic int pos(input logic [1:0] ph);
    logic [1:0] seq [4];
    int p;
    seq = '{2'b00, 2'b01, 2'b11, 2'b10};
    p = 0;
    for (int i = 0; i < 4; i++) if (seq[i] == ph) p = i;
    return p;
  endfunction

  // One clock: observe outputs at the falling edge, return 1 time unit past the next rising edge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (step === 1'b1 || err === 1'b1) begin
      pulse_cnt++;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_pulse cyc=%0d step=%b err=%b up_down=%b required no pulse",
                 cyc, step, err, up_down);
      end else begin
        e = exp_q.pop_front();
        if (cyc !== e.cyc || step !== e.step || err !== e.err || up_down !== e.ud) begin
          miscompares++;
          $display("FAIL scoreboard got cyc=%0d step=%b err=%b ud=%b required cyc=%0d step=%b err=%b ud=%b",
                   cyc, step, err, up_down, e.cyc, e.step, e.err, e.ud);
        end
      end
    end
    if (exp_q.size() != 0 && cyc > exp_q[0].cyc) begin
      vectors++;
      miscompares++;
      $display("FAIL missing_pulse cyc=%0d got none required pulse at cyc=%0d", cyc, exp_q[0].cyc);
      void'(exp_q.pop_front());
    end
    vectors++;
    if (up_down !== last_ud && step !== 1'b1) begin
      miscompares++;
      $display("FAIL ud_without_step cyc=%0d got up_down=%b required %b", cyc, up_down, last_ud);
    end
    last_ud = up_down;
    @(posedge clk);
    #1;
  endtask

  // Drive a new {A,B} phase and push the outcome the decoder must report.
  task automatic drive_phase(input logic [1:0] ph, input int hold);
    exp_t e;
    {a_in, b_in} = ph;
    if (ph != model_ph) begin
      e.cyc = cyc + LAT;
      if (pos(ph) == (pos(model_ph) + 1) % 4) begin
        model_ud = UP;
        e.step = 1'b1; e.err = 1'b0; e.ud = UP;
      end else if (pos(model_ph) == (pos(ph) + 1) % 4) begin
        model_ud = DOWN;
        e.step = 1'b1; e.err = 1'b0; e.ud = DOWN;
      end else begin
        e.step = 1'b0; e.err = 1'b1; e.ud = model_ud;
      end
      exp_q.push_back(e);
      model_ph = ph;
    end
    repeat (hold) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; a_in = 1'b1; b_in = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if (step !== 1'b0 || err !== 1'b0 || up_down !== 1'b1 || dut.prev !== 2'b00 || dut.state !== ST_INIT) begin
      miscompares++;
      $display("FAIL reset_values got step=%b err=%b ud=%b prev=%b state=%b required 0 0 1 00 INIT",
               step, err, up_down, dut.prev, dut.state);
    end
    last_ud = up_down;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      vectors++;
      if (dut.state !== ((i < 3) ? ST_INIT : ST_RUN)) begin
        miscompares++;
        $display("FAIL init_length edge=%0d got state=%b required %b", i, dut.state, (i < 3) ? ST_INIT : ST_RUN);
      end
    end
    repeat (7) tick();
    vectors++;
    if (dut.prev !== 2'b11 || up_down !== 1'b1 || step !== 1'b0 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_at_11 got prev=%b ud=%b step=%b err=%b required 11 1 0 0",
               dut.prev, up_down, step, err);
    end
    model_ph = 2'b11;
    model_ud = UP;
  endtask

  task automatic test_up();
    int start;
    start = pulse_cnt;
    drive_phase(2'b10, 8);
    drive_phase(2'b00, 8);
    drive_phase(2'b01, 8);
    drive_phase(2'b11, 8);
    drive_phase(2'b10, 8);
    drive_phase(2'b00, 8);
    repeat (2) tick();
    vectors++;
    if (pulse_cnt - start !== 6 || exp_q.size() != 0 || up_down !== 1'b1) begin
      miscompares++;
      $display("FAIL up_sequence got pulses=%0d pending=%0d ud=%b required 6 0 1",
               pulse_cnt - start, exp_q.size(), up_down);
    end
  endtask

  task automatic test_down();
    int start;
    start = pulse_cnt;
    drive_phase(2'b10, 8);
    drive_phase(2'b11, 8);
    drive_phase(2'b01, 8);
    drive_phase(2'b00, 8);
    repeat (2) tick();
    vectors++;
    if (pulse_cnt - start !== 4 || exp_q.size() != 0 || up_down !== 1'b0) begin
      miscompares++;
      $display("FAIL down_sequence got pulses=%0d pending=%0d ud=%b required 4 0 0",
               pulse_cnt - start, exp_q.size(), up_down);
    end
  endtask

  task automatic test_glitch();
    int start;
    start = pulse_cnt;
    a_in = 1'b1;
    repeat (3) tick();
    a_in = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      vectors++;
      if (dut.u_deb_a.dout !== 1'b0) begin
        miscompares++;
        $display("FAIL glitch_deb_a cycle=%0d got %b required 0", i, dut.u_deb_a.dout);
      end
    end
    vectors++;
    if (pulse_cnt !== start) begin
      miscompares++;
      $display("FAIL glitch_pulses got %0d required 0", pulse_cnt - start);
    end
  endtask

  task automatic test_double();
    drive_phase(2'b11, 10);
    vectors++;
    if (up_down !== 1'b0 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL double_edge got ud=%b pending=%0d required 0 0", up_down, exp_q.size());
    end
    drive_phase(2'b10, 8);
    drive_phase(2'b00, 8);
    vectors++;
    if (up_down !== 1'b1 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL after_double got ud=%b pending=%0d required 1 0", up_down, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int start;
    start = pulse_cnt;
    a_in = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    tick();
    vectors++;
    if (step !== 1'b0 || err !== 1'b0 || up_down !== 1'b1 || dut.prev !== 2'b00 ||
        dut.state !== ST_INIT || dut.u_deb_a.dout !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset_values got step=%b err=%b ud=%b prev=%b state=%b deb_a=%b required 0 0 1 00 INIT 0",
               step, err, up_down, dut.prev, dut.state, dut.u_deb_a.dout);
    end
    rst = 1'b0;
    last_ud = UP;
    for (int i = 1; i <= 3; i++) begin
      tick();
      vectors++;
      if (dut.state !== ((i < 3) ? ST_INIT : ST_RUN)) begin
        miscompares++;
        $display("FAIL mid_init_length edge=%0d got state=%b required %b", i, dut.state, (i < 3) ? ST_INIT : ST_RUN);
      end
    end
    repeat (12) tick();
    vectors++;
    if (pulse_cnt !== start || dut.prev !== 2'b10) begin
      miscompares++;
      $display("FAIL mid_reset_quiet got pulses=%0d prev=%b required 0 10", pulse_cnt - start, dut.prev);
    end
    model_ph = 2'b10;
    model_ud = UP;
    drive_phase(2'b00, 10);
    vectors++;
    if (exp_q.size() != 0 || pulse_cnt - start !== 1) begin
      miscompares++;
      $display("FAIL post_reset_step got pulses=%0d pending=%0d required 1 0", pulse_cnt - start, exp_q.size());
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    pulse_cnt   = 0;
    last_ud     = 1'b1;
    model_ph    = 2'b00;
    model_ud    = UP;
    rst         = 1'b1;
    a_in        = 1'b0;
    b_in        = 1'b0;
    test_reset();
    test_up();
    test_down();
    test_glitch();
    test_double();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/quad_decoder.md
# quad_decoder

Quadrature decoder that turns two asynchronous encoder channels (A, B) into a direction signal and a one-cycle step strobe. It sits directly upstream of the up/down counter stage: `up_down` drives the counter's direction input, and `step` qualifies each count. Each channel is synchronised and debounced before decode, and illegal double-edge transitions are flagged.

## Interface
- `DEB_CYCLES`, default 4: consecutive cycles a synchronised channel must differ from its debounced value before the debounced value updates; legal range 1..255.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: synchronous reset, active-high.
- `a_in` in 1: encoder channel A, asynchronous.
- `b_in` in 1: encoder channel B, asynchronous.
- `step` out 1: one-cycle pulse per legal quadrature transition.
- `up_down` out 1: direction of the most recent legal transition; 1 = up, 0 = down.
- `err` out 1: one-cycle pulse when both debounced channels change in the same cycle.

## Operation
- Synchroniser: two flops per channel (`s1`, `s2`); reset value 0.
- Debounce, per channel:
  - A counter of width `$clog2(DEB_CYCLES+1)` runs while `s2 != deb`.
  - When `s2 != deb` and the counter equals `DEB_CYCLES-1`, `deb` loads `s2` and the counter clears.
  - When `s2 == deb`, the counter clears, so glitches shorter than `DEB_CYCLES` are dropped.
- Decode state `prev[1:0] = {A,B}` is compared against `cur = {deb_a, deb_b}`.
  - Up sequence: 00→01→11→10→00.
  - Down sequence: the reverse.
- State machine, encoding INIT=0, RUN=1:
  - INIT, entered on reset: `deb_a`/`deb_b` load `s2` directly every cycle (no filtering) and `prev` loads `cur`; `step`/`err` are held 0. After 3 cycles in INIT, go to RUN. This prevents a false step or error when the encoder rests at non-00 out of reset.
  - RUN: every cycle `prev <= cur`.
    - `cur == prev`: nothing.
    - `cur` is the up-neighbour of `prev`: `step=1`, `up_down<=1`.
    - `cur` is the down-neighbour of `prev`: `step=1`, `up_down<=0`.
    - Both bits differ: `err=1`; no step; `up_down` holds.
- `step` and `err` are never asserted together.
- `up_down` changes only with a step, in the same cycle the step is asserted.
- Reset values: `step=0`, `err=0`, `up_down=1`, `prev=00`, `deb=00`, counters 0, state INIT.
- Reset mid-operation: all of the above are restored on the next edge with no pulse emitted, and the block re-enters INIT.

## Timing
- Latency, counted from the edge that first samples a new `a_in`/`b_in` level (edge 1) in RUN:
  - `s2` updates at edge 2.
  - `deb` updates at edge 2+`DEB_CYCLES`.
  - `step`/`err`/`up_down` are registered at edge 3+`DEB_CYCLES` and high for exactly one cycle.
- Maximum legal step rate: one transition per `DEB_CYCLES`+1 cycles per channel. Faster input is filtered, not queued.
- If both channels mature in the same cycle, `err` is reported; if they mature in different cycles, two separate steps are reported.
- INIT lasts exactly 3 cycles after `rst` deasserts.
- No backpressure: `step` is a strobe and the consumer must sample it every cycle.

## Structure
- Package `quad_pkg` holds:
  - the state encoding (`ST_INIT`, `ST_RUN`) and the INIT length constant (3);
  - `UP=1'b1`, `DOWN=1'b0`;
  - a function mapping a 2-bit phase to its up-neighbour.
- One sub-module, `debounce_filter` (parameter `DEB_CYCLES`; ports `clk`, `rst`, `bypass`, `din`, `dout`). It contains the synchroniser and filter and is instantiated once per channel. `bypass` is driven high in INIT.
- The top holds the FSM, `prev`, and the decode and output registers. Target is roughly 150–250 lines total.

## Test plan
- Reset with `a_in=1`, `b_in=1`, held 10 cycles after release: `step` and `err` stay 0, `up_down=1`, internal `prev=11`.
- With `DEB_CYCLES=4`, drive 00→01→11→10→00, each level held 8 cycles: 4 `step` pulses, each 7 cycles after the input change; `up_down=1` throughout.
- Drive the reverse sequence 00→10→11→01→00: 4 steps; `up_down` goes to 0 with the first step and stays 0.
- Glitch `a_in` high for 3 cycles, then low (`DEB_CYCLES=4`): no `step`, no `err`, debounced A stays 0.
- From 00, switch both channels to 11 on the same edge: a single `err` pulse at edge 7, no `step`, `up_down` unchanged; a following 11→10 produces a normal up step.
- Assert `rst` for 1 cycle, 2 cycles after a channel change, before the step emerges: no `step` or `err` pulse, outputs return to reset values, and 3 INIT cycles follow.
